// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared key indices, auto-repeat channel state encoding and
//                command priority order for the key_repeat stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int NUM_KEYS = 4;

    typedef logic [1:0] key_idx_t;

    // Bit positions in held / pending / command vectors.
    localparam key_idx_t KEY_ROT   = 2'd0;
    localparam key_idx_t KEY_LEFT  = 2'd1;
    localparam key_idx_t KEY_RIGHT = 2'd2;
    localparam key_idx_t KEY_DOWN  = 2'd3;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_DELAY  = 2'd1,
        CH_REPEAT = 2'd2
    } chan_state_e;

    // Highest priority first.
    localparam key_idx_t PRIO_ORDER [NUM_KEYS] = '{KEY_ROT, KEY_DOWN, KEY_LEFT, KEY_RIGHT};

    // One-hot pick of the highest-priority requesting key (zero if none).
    function automatic logic [NUM_KEYS-1:0] pick_cmd(input logic [NUM_KEYS-1:0] req);
        logic [NUM_KEYS-1:0] g;
        g = '0;
        if (req[PRIO_ORDER[0]])      g[PRIO_ORDER[0]] = 1'b1;
        else if (req[PRIO_ORDER[1]]) g[PRIO_ORDER[1]] = 1'b1;
        else if (req[PRIO_ORDER[2]]) g[PRIO_ORDER[2]] = 1'b1;
        else if (req[PRIO_ORDER[3]]) g[PRIO_ORDER[3]] = 1'b1;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_chan.sv
`default_nettype none
// ============================================================================
//  Module      : key_chan
//  Description : One key's auto-repeat channel: IDLE/DELAY/REPEAT FSM, its
//                cycle counter and a single-deep pending command bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_chan
    import tetris_pkg::*;
#(
    parameter int   DELAY_CYC = 25_000_000,
    parameter int   RATE_CYC  = 5_000_000,
    parameter bit   REPEAT_EN = 1'b1,
    parameter int   CNT_W     = 25
) (
    input  logic clk,
    input  logic clr,
    input  logic i_lvl,
    input  logic i_inhibit,
    input  logic i_clear_pending,
    output logic o_pending
);

    localparam logic [CNT_W-1:0] C_DLY_LAST  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] C_RATE_LAST = CNT_W'(RATE_CYC - 1);

    chan_state_e      r_state;
    chan_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_prev;
    logic             r_pending;
    logic             w_set;

    // Next-state, counter and request generation.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set       = 1'b0;
        if (!i_lvl) begin
            w_state_nxt = CH_IDLE;
            w_cnt_nxt   = '0;
        end else if (!i_inhibit) begin
            // While inhibited the channel is frozen: no requests, counter held.
            case (r_state)
                CH_IDLE: begin
                    if (!r_prev) begin
                        w_state_nxt = CH_DELAY;
                        w_cnt_nxt   = '0;
                        w_set       = 1'b1;
                    end
                end
                CH_DELAY: begin
                    if (r_cnt == C_DLY_LAST) begin
                        // Non-repeating keys park here with the counter saturated.
                        if (REPEAT_EN) begin
                            w_state_nxt = CH_REPEAT;
                            w_cnt_nxt   = '0;
                            w_set       = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                CH_REPEAT: begin
                    if (r_cnt == C_RATE_LAST) begin
                        w_cnt_nxt = '0;
                        w_set     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = CH_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter, edge-detect and pending registers; a new request wins
    // over a same-cycle grant so it is never lost.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= CH_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prev    <= i_lvl;
            r_pending <= w_set | (r_pending & ~i_clear_pending);
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat
//  Description : DAS-style auto-repeat and fixed-priority arbitration of the
//                four debounced button levels into single-cycle commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_repeat
    import tetris_pkg::*;
#(
    parameter int         DELAY_CYC   = 25_000_000,
    parameter int         RATE_CYC    = 5_000_000,
    parameter logic [3:0] REPEAT_MASK = 4'b1110
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rotate_lvl,
    input  logic       left_lvl,
    input  logic       right_lvl,
    input  logic       down_lvl,
    input  logic       ready,
    output logic       rotate,
    output logic       left,
    output logic       right,
    output logic       down,
    output logic [3:0] held
);

    localparam int C_MAXC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int C_CNT_W = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

    logic [NUM_KEYS-1:0] w_lvl;
    logic [NUM_KEYS-1:0] w_inh;
    logic [NUM_KEYS-1:0] w_pend;
    logic [NUM_KEYS-1:0] w_grant;
    logic [NUM_KEYS-1:0] r_cmd;
    logic [NUM_KEYS-1:0] r_held;
    logic                w_lr_both;

    assign w_lvl[KEY_ROT]   = rotate_lvl;
    assign w_lvl[KEY_LEFT]  = left_lvl;
    assign w_lvl[KEY_RIGHT] = right_lvl;
    assign w_lvl[KEY_DOWN]  = down_lvl;

    assign w_lr_both = left_lvl & right_lvl;

    // Left and right freeze each other while both are held.
    always_comb begin
        w_inh            = '0;
        w_inh[KEY_LEFT]  = w_lr_both;
        w_inh[KEY_RIGHT] = w_lr_both;
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_chan #(
            .DELAY_CYC (DELAY_CYC),
            .RATE_CYC  (RATE_CYC),
            .REPEAT_EN (REPEAT_MASK[gi]),
            .CNT_W     (C_CNT_W)
        ) u_chan (
            .clk             (clk),
            .clr             (clr),
            .i_lvl           (w_lvl[gi]),
            .i_inhibit       (w_inh[gi]),
            .i_clear_pending (w_grant[gi]),
            .o_pending       (w_pend[gi])
        );
    end

    // The granted key both pulses next cycle and has its pending bit cleared.
    assign w_grant = ready ? pick_cmd(w_pend) : '0;

    // Registered command pulses and held copy of the levels.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cmd  <= '0;
            r_held <= '0;
        end else begin
            r_cmd  <= w_grant;
            r_held <= w_lvl;
        end
    end

    assign rotate = r_cmd[KEY_ROT];
    assign left   = r_cmd[KEY_LEFT];
    assign right  = r_cmd[KEY_RIGHT];
    assign down   = r_cmd[KEY_DOWN];
    assign held   = r_held;

endmodule
`default_nettype wire

// File: tb/tb_key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_repeat
//  Description : Scoreboard bench for key_repeat with DELAY_CYC=4, RATE_CYC=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeat;

    localparam logic [3:0] C_ROT   = 4'b0001;
    localparam logic [3:0] C_LEFT  = 4'b0010;
    localparam logic [3:0] C_RIGHT = 4'b0100;
    localparam logic [3:0] C_DOWN  = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rotate_lvl = 1'b0;
    logic       left_lvl = 1'b0;
    logic       right_lvl = 1'b0;
    logic       down_lvl = 1'b0;
    logic       ready = 1'b1;
    logic       rotate, left, right, down;
    logic [3:0] held;
    logic [3:0] w_cmd;

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    exp_t q[$];

    key_repeat #(
        .DELAY_CYC   (4),
        .RATE_CYC    (2),
        .REPEAT_MASK (4'b1110)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .rotate_lvl (rotate_lvl),
        .left_lvl   (left_lvl),
        .right_lvl  (right_lvl),
        .down_lvl   (down_lvl),
        .ready      (ready),
        .rotate     (rotate),
        .left       (left),
        .right      (right),
        .down       (down),
        .held       (held)
    );

    assign w_cmd = {down, right, left, rotate};

    always #5 clk = ~clk;

    // Edge counter: after the Nth rising edge, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect a pulse 'off' edges after the current one.
    task automatic expect_at(input int off, input logic [3:0] cmd);
        exp_t e;
        e.cyc = cyc + off;
        e.cmd = cmd;
        q.push_back(e);
    endtask

    // Monitor: every observed pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!clr && w_cmd != 4'b0000) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", int'(w_cmd), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cmd", int'(w_cmd), int'(e.cmd));
                chk("pulse_cyc", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state, with a level high to show held is forced low.
        rotate_lvl = 1'b1;
        step(3);
        chk("reset_cmd", int'(w_cmd), 0);
        chk("reset_held", int'(held), 0);
        rotate_lvl = 1'b0;
        step(1);
        clr = 1'b0;
        step(2);

        // Tap left for one cycle: single pulse, no repeat.
        left_lvl = 1'b1;
        expect_at(2, C_LEFT);
        step(1);
        chk("held_left", int'(held), int'(C_LEFT));
        left_lvl = 1'b0;
        step(10);

        // Hold down 12 cycles: pulses at +2, +6, +8, +10, +12.
        down_lvl = 1'b1;
        expect_at(2, C_DOWN);
        expect_at(6, C_DOWN);
        expect_at(8, C_DOWN);
        expect_at(10, C_DOWN);
        expect_at(12, C_DOWN);
        step(12);
        down_lvl = 1'b0;
        step(8);

        // Rotate held 20 cycles, masked from repeating: one pulse.
        rotate_lvl = 1'b1;
        expect_at(2, C_ROT);
        step(20);
        rotate_lvl = 1'b0;
        step(5);

        // Simultaneous rotate/down/left: priority order over 3 cycles.
        rotate_lvl = 1'b1;
        down_lvl   = 1'b1;
        left_lvl   = 1'b1;
        expect_at(2, C_ROT);
        expect_at(3, C_DOWN);
        expect_at(4, C_LEFT);
        step(1);
        rotate_lvl = 1'b0;
        down_lvl   = 1'b0;
        left_lvl   = 1'b0;
        step(8);

        // Backpressure: right tapped while not ready, issued once ready.
        ready     = 1'b0;
        right_lvl = 1'b1;
        expect_at(6, C_RIGHT);
        step(1);
        right_lvl = 1'b0;
        step(4);
        ready = 1'b1;
        step(6);

        // Left and right together: no pulses at all.
        left_lvl  = 1'b1;
        right_lvl = 1'b1;
        step(15);
        left_lvl  = 1'b0;
        right_lvl = 1'b0;
        step(5);

        // Async reset while down is held and pending (ready low keeps it pending).
        ready    = 1'b0;
        down_lvl = 1'b1;
        step(3);
        chk("held_before_clr", int'(held), int'(C_DOWN));
        #1;
        clr   = 1'b1;
        ready = 1'b1;
        #1;
        chk("clr_immediate_held", int'(held), 0);
        chk("clr_immediate_cmd", int'(w_cmd), 0);
        step(2);
        clr = 1'b0;
        expect_at(2, C_DOWN);
        step(2);
        down_lvl = 1'b0;
        step(6);

        // Every expected pulse must have been seen.
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_repeat.md
# key_repeat

Auto-repeat and arbitration stage between the four button debouncers and the game controller. It takes the debounced rotate/left/right/down levels and turns them into single-cycle command pulses. A held key repeats after an initial delay, in the same way as handheld Tetris DAS. At most one command pulse is issued per cycle, and only while the controller signals it can accept one.

## Interface
Parameters:
- DELAY_CYC, 25_000_000: cycles a key must stay held after its first pulse before auto-repeat starts (250 ms at 100 MHz).
- RATE_CYC, 5_000_000: cycles between repeat pulses once repeating (50 ms at 100 MHz).
- REPEAT_MASK, 4'b1110: per-key repeat enable, bit0 rotate, bit1 left, bit2 right, bit3 down. Rotate never repeats by default.

Ports:
- clk  in  1  system clock; single clock domain.
- clr  in  1  asynchronous, active-high reset.
- rotate_lvl / left_lvl / right_lvl / down_lvl  in  1 each  debounced button levels, synchronous to clk.
- ready  in  1  controller can accept a command this cycle.
- rotate / left / right / down  out  1 each  registered single-cycle command pulses.
- held  out  4  registered copy of the key levels, same bit order as REPEAT_MASK.

## Operation
- Each key has its own channel FSM with three states: IDLE, DELAY and REPEAT.
  - IDLE → DELAY on a rising edge of the level (lvl=1, prev=0). The channel's pending bit is set and the counter is cleared.
  - DELAY: the counter increments while the level stays 1. When it reaches DELAY_CYC-1 and the mask bit is 1, pending is set, the counter is cleared and the FSM goes to REPEAT. If the mask bit is 0, the FSM stays in DELAY and the counter saturates.
  - REPEAT: the counter increments. At RATE_CYC-1, pending is set and the counter is cleared.
  - From any state, level 0 → IDLE with the counter cleared. Pending is not cleared by release, so a tap is never lost.
- A request that arrives while pending is already 1 merges into it; requests are not counted and nothing queues deeper than one.
- Left and right are mutually exclusive. While both levels are 1, neither channel sets pending, and both counters hold their values.
- Arbitration: if ready=1 and any pending bit is set, exactly one output pulses on the next cycle and its pending bit clears. Fixed priority is rotate > down > left > right.
- If ready=0, no pulses are issued and pending bits persist.
- Counter width is $clog2(max(DELAY_CYC,RATE_CYC)). Counters never wrap: they either clear or saturate.
- Reset state: all FSMs IDLE, counters 0, pending 0, prev 0. All outputs, including held, are 0 while clr=1. Reset asserted mid-hold discards all pending bits. After clr is released, a key that is still held is treated as a new rising edge.

## Timing
- Press latency: the level goes high before clock edge k, pending is set at edge k, and the pulse is high for the cycle after edge k+1, provided ready=1 at edge k+1. Latency is 2 edges.
- Repeat cadence while held and uncontended: the first pulse comes at press+2, the second DELAY_CYC edges after the first, then one every RATE_CYC edges.
- A pulse is high for exactly 1 cycle. Two pulses on the same output are at least 2 cycles apart, because pending must re-set before it can be issued again.
- A pulse lost to arbitration stays pending and is delayed, not dropped. Throughput is 1 command per cycle.
- held is the level delayed by 1 edge.

## Structure
- tetris_pkg holds the shared constants:
  - key index constants KEY_ROT=0, KEY_LEFT=1, KEY_RIGHT=2, KEY_DOWN=3;
  - the channel state encoding (IDLE/DELAY/REPEAT);
  - the priority order.
  The control block reuses these for its command decode.
- Sub-module key_chan: one channel FSM, its counter and its pending bit, with a clear_pending input. It is instantiated 4 times. The top level holds the left/right inhibit, the arbiter and the output registers.

## Test plan
All scenarios use DELAY_CYC=4 and RATE_CYC=2.
- Tap: left_lvl high for 1 cycle with ready=1 → left pulses exactly once, 2 edges later. No repeat occurs.
- Hold: down_lvl held for 12 cycles with ready=1 → down pulses at cycles 2, 6, 8, 10 and 12 after the press. Release → no further pulses.
- Rotate hold with the default mask: 20 cycles held → exactly 1 rotate pulse.
- Contention: rotate, down and left all rise in the same cycle → pulses in consecutive cycles in the order rotate, down, left.
- Backpressure: ready=0 while right is tapped and released, then ready=1 five cycles later → 1 right pulse on the following cycle. Both left and right held → no left or right pulses.
- Reset: clr asserted asynchronously while down is held and pending → all outputs 0 immediately. After release with down still high → a pulse 2 edges later.
